// File: rtl/pe_switch_seq.sv
// rtl/pe_switch_seq.sv - context-sequenced crossbar select generator for a PE switch
//
// Steps through a small table of crossbar contexts. Each context holds for
// (dwell + 1) cycles, then the sequence advances, wraps, or finishes.
//
// Parameters:
//   DEPTH     number of context entries (power of two, 2..16)
//   AW        context address width, log2(DEPTH)
// Ports:
//   clk       single clock, rising edge
//   rst_n     asynchronous active-low reset
//   cfg_we    context-table write strobe (honoured only in IDLE)
//   cfg_addr  context-table write index
//   cfg_data  table entry {dwell[11:8], switch[7:0]}
//   cfg_last  index of the last context, captured on an accepted start
//   loop_en   wrap to context 0 after the last context, sampled every cycle
//   start     single-cycle run request
//   stop      abort request, wins over everything else in RUN
//   switch    registered crossbar select {N_sel, S_sel, W_sel, E_sel}
//   ctx_idx   index of the context currently driven
//   busy      high while in RUN
//   done      one-cycle pulse on normal completion

module pe_switch_seq #(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cfg_we,
    input  logic [AW-1:0] cfg_addr,
    input  logic [11:0]   cfg_data,
    input  logic [AW-1:0] cfg_last,
    input  logic          loop_en,
    input  logic          start,
    input  logic          stop,
    output logic [7:0]    switch,
    output logic [AW-1:0] ctx_idx,
    output logic          busy,
    output logic          done
);

    localparam logic [7:0]  SW_IDENT  = 8'h1B;
    localparam logic [11:0] ENTRY_RST = 12'h01B;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [11:0]   tbl [DEPTH];
    logic [3:0]    cnt_q, cnt_d;
    logic [AW-1:0] last_q, last_d;
    logic [7:0]    switch_d;
    logic [AW-1:0] idx_d;
    logic          busy_d;
    logic          done_d;

    logic [11:0]   entry_first;
    logic [11:0]   entry_next;
    logic [11:0]   entry_wrap;
    logic [AW-1:0] idx_inc;

    // Context table. Writes are locked out while a program runs so the
    // sequence being played can never change underneath itself.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                tbl[i] <= ENTRY_RST;
            end
        end else if (cfg_we && state_q == IDLE) begin
            tbl[cfg_addr] <= cfg_data;
        end
    end

    // A write to entry 0 in the same cycle as start must take effect, so the
    // incoming data bypasses the table on the launch load.
    assign entry_first = (cfg_we && cfg_addr == '0) ? cfg_data : tbl[0];
    // AW-bit arithmetic wraps modulo DEPTH, keeping every lookup in range.
    assign idx_inc     = ctx_idx + AW'(1);
    assign entry_next  = tbl[idx_inc];
    assign entry_wrap  = tbl[0];

    always_comb begin
        state_d  = state_q;
        switch_d = switch;
        idx_d    = ctx_idx;
        busy_d   = busy;
        done_d   = 1'b0;
        cnt_d    = cnt_q;
        last_d   = last_q;

        unique case (state_q)
            IDLE: begin
                switch_d = SW_IDENT;
                idx_d    = '0;
                busy_d   = 1'b0;
                cnt_d    = 4'd0;
                if (start && !stop) begin
                    state_d  = RUN;
                    last_d   = cfg_last;
                    switch_d = entry_first[7:0];
                    cnt_d    = entry_first[11:8];
                    busy_d   = 1'b1;
                end
            end
            RUN: begin
                if (stop) begin
                    state_d  = IDLE;
                    switch_d = SW_IDENT;
                    idx_d    = '0;
                    busy_d   = 1'b0;
                    cnt_d    = 4'd0;
                end else if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else if (ctx_idx != last_q) begin
                    idx_d    = idx_inc;
                    switch_d = entry_next[7:0];
                    cnt_d    = entry_next[11:8];
                end else if (loop_en) begin
                    idx_d    = '0;
                    switch_d = entry_wrap[7:0];
                    cnt_d    = entry_wrap[11:8];
                end else begin
                    state_d  = IDLE;
                    switch_d = SW_IDENT;
                    idx_d    = '0;
                    busy_d   = 1'b0;
                    done_d   = 1'b1;
                    cnt_d    = 4'd0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            switch  <= SW_IDENT;
            ctx_idx <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            cnt_q   <= 4'd0;
            last_q  <= '0;
        end else begin
            state_q <= state_d;
            switch  <= switch_d;
            ctx_idx <= idx_d;
            busy    <= busy_d;
            done    <= done_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
        end
    end

endmodule

// File: doc/pe_switch_seq.md
PE_SWITCH_SEQ -- requirements
Module: pe_switch_seq

Interface
REQ-001 The block SHALL have parameter DEPTH, default 8, giving the number of context entries (power of two, 2..16).
REQ-002 The block SHALL have parameter AW, default 3, giving the context address width (log2 DEPTH).
REQ-003 The block SHALL have port clk, input, 1 bit: single clock; all state is updated on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The block SHALL have port cfg_we, input, 1 bit: context-table write strobe.
REQ-006 The block SHALL have port cfg_addr, input, AW bits: context-table write index.
REQ-007 The block SHALL have port cfg_data, input, 12 bits: {dwell[11:8], switch[7:0]} entry.
REQ-008 The block SHALL have port cfg_last, input, AW bits: index of the last context; sampled on an accepted start.
REQ-009 The block SHALL have port loop_en, input, 1 bit: wrap to index 0 after the last context; sampled every cycle.
REQ-010 The block SHALL have port start, input, 1 bit: single-cycle run request.
REQ-011 The block SHALL have port stop, input, 1 bit: abort request.
REQ-012 The block SHALL have port switch, output, 8 bits: registered crossbar select {N_sel,S_sel,W_sel,E_sel}.
REQ-013 The block SHALL have port ctx_idx, output, AW bits: index of the context currently driven.
REQ-014 The block SHALL have port busy, output, 1 bit: high while in RUN.
REQ-015 The block SHALL have port done, output, 1 bit: one-cycle completion pulse.

Function
REQ-016 The FSM SHALL have two states, IDLE and RUN; every output SHALL be driven from a register.
REQ-017 The table SHALL be DEPTH x 12-bit registers, written on the clk edge when cfg_we=1 in IDLE; cfg_we in RUN SHALL be ignored.
REQ-018 In IDLE, switch SHALL be 8'h1B (identity: N->N, S->S, W->W, E->E), ctx_idx 0, busy 0.
REQ-019 start=1 and stop=0 in IDLE SHALL latch cfg_last, load index 0 and its dwell, and enter RUN, so switch=table[0].switch, busy=1 on the edge after start (latency 1).
REQ-020 A same-cycle write to entry 0 together with start SHALL be visible; the written value is forwarded to switch.
REQ-021 In RUN, each context SHALL be held for dwell+1 cycles (dwell 0 = 1 cycle, 15 = 16 cycles) using a 4-bit down-counter.
REQ-022 When the count expires and idx < last, the block SHALL advance to idx+1 on the next edge, loading the next switch and dwell.
REQ-023 When the count expires and idx == last with loop_en=1, the block SHALL wrap to index 0 and remain in RUN; done SHALL stay 0.
REQ-024 When the count expires and idx == last with loop_en=0, the block SHALL move to IDLE on the next edge, restore the REQ-018 values and pulse done=1 for exactly that cycle.
REQ-025 cfg_last=0 SHALL run only context 0; that is a legal single-context program.
REQ-026 stop=1 in RUN SHALL force IDLE on the next edge with REQ-018 values and done=0; stop has priority over expiry.
REQ-027 start in RUN SHALL be ignored; start and stop together in IDLE SHALL leave the block in IDLE.
REQ-028 The index SHALL wrap modulo DEPTH; no out-of-range access SHALL be possible.

Reset
REQ-029 rst_n=0 SHALL immediately force IDLE, switch=8'h1B, ctx_idx=0, busy=0, done=0, and clear the dwell counter and latched last.
REQ-030 Table contents SHALL reset to 12'h01B in every entry, so an unprogrammed run drives identity routing.
REQ-031 Reset asserted mid-RUN SHALL abort with no done pulse; operation resumes only on a new start after deassertion.

Verification
REQ-032 Reset check: after reset, run with cfg_last=0 and loop_en=0 -> switch=8'h1B for 1 cycle, then done pulse.
REQ-033 Program table[0]=12'h0E4, table[1]=12'h21B, table[2]=12'h0AA; cfg_last=2, loop_en=0, start at T -> switch=E4 at T+1, 1B at T+2..T+4, AA at T+5, IDLE with done=1 and switch=1B at T+6.
REQ-034 Same program with loop_en=1 -> sequence E4,1B,1B,1B,AA,E4,... repeats with busy=1 and no done; stop at T+7 -> IDLE and switch=1B at T+8, done=0.
REQ-035 cfg_we to entry 1 in RUN with data 12'h000 -> table unchanged; entry 1 still shows 8'h1B for 3 cycles.
REQ-036 Assert rst_n low mid-dwell at entry 1 -> outputs immediately at REQ-029 values; start after release -> sequence restarts at index 0 with entries reset to 12'h01B.
REQ-037 With DEPTH=8, cfg_last=7, loop_en=1 and all dwell 0 -> ctx_idx 0..7,0,1 on consecutive cycles, wrap without a gap.
